// File: rtl/frame_sum_accumulator_if.sv
`timescale 1ns/1ps
// frame_sum_accumulator_if
// Bundles the result-input handshake and the frame-output handshake of
// frame_sum_accumulator.
//   sum_in        : 6-bit adder sum (two's complement, possibly wrapped)
//   ovf_in        : signed-overflow flag belonging to sum_in
//   in_valid      : sum_in/ovf_in valid this cycle
//   in_ready      : accumulator takes a result this cycle
//   frame_sum     : signed sum of the last completed frame (ACC_W bits)
//   frame_ovf_cnt : overflowed results in the last completed frame
//   out_valid     : an unconsumed frame is presented
//   out_ready     : consumer accepts the presented frame
// master = producer/consumer environment, slave = the accumulator.
interface frame_sum_accumulator_if #(
    parameter int ACC_W = 10
);
    logic [5:0]              sum_in;
    logic                    ovf_in;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [ACC_W-1:0] frame_sum;
    logic [4:0]              frame_ovf_cnt;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output sum_in, ovf_in, in_valid, out_ready,
        input  in_ready, frame_sum, frame_ovf_cnt, out_valid
    );

    modport slave (
        input  sum_in, ovf_in, in_valid, out_ready,
        output in_ready, frame_sum, frame_ovf_cnt, out_valid
    );
endinterface

// File: rtl/frame_sum_accumulator.sv
`timescale 1ns/1ps
// frame_sum_accumulator
// Takes one 6-bit adder result (sum + overflow flag) per cycle, rebuilds
// its exact 7-bit signed value, sums FRAME_LEN of them and counts the
// overflowed ones, then presents the frame on a valid/ready handshake
// and holds it until the consumer takes it.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clear : synchronous frame abort (drops the current frame / HOLD frame)
//   bus   : frame_sum_accumulator_if.slave (input and output handshakes)
// Parameters: FRAME_LEN (2..16), ACC_W >= 7 + clog2(FRAME_LEN).
module frame_sum_accumulator #(
    parameter int FRAME_LEN = 4,
    parameter int ACC_W     = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    frame_sum_accumulator_if.slave    bus
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(FRAME_LEN - 1);

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [4:0]              ocnt_q, ocnt_d;
    logic signed [ACC_W-1:0] frame_sum_q, frame_sum_d;
    logic [4:0]              frame_ovf_cnt_q, frame_ovf_cnt_d;

    logic [6:0]              val7;
    logic signed [ACC_W-1:0] val_ext;
    logic                    accept;

    // An overflowed 6-bit sum has the wrong sign bit; flipping it and
    // prepending gives the true 7-bit result of the adder.
    assign val7    = {bus.sum_in[5] ^ bus.ovf_in, bus.sum_in};
    assign val_ext = {{(ACC_W-7){val7[6]}}, val7};
    assign accept  = bus.in_valid && (state_q == ST_ACC);

    always_comb begin
        state_d         = state_q;
        acc_d           = acc_q;
        cnt_d           = cnt_q;
        ocnt_d          = ocnt_q;
        frame_sum_d     = frame_sum_q;
        frame_ovf_cnt_d = frame_ovf_cnt_q;

        if (clear) begin
            // Abort: the published frame values stay, everything else restarts.
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ocnt_d  = '0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        if (cnt_q == CNT_LAST) begin
                            frame_sum_d     = acc_q + val_ext;
                            frame_ovf_cnt_d = ocnt_q + {4'b0000, bus.ovf_in};
                            acc_d           = '0;
                            cnt_d           = '0;
                            ocnt_d          = '0;
                            state_d         = ST_HOLD;
                        end else begin
                            acc_d  = acc_q + val_ext;
                            ocnt_d = ocnt_q + {4'b0000, bus.ovf_in};
                            cnt_d  = cnt_q + 4'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state_d = ST_ACC;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_ACC;
            acc_q           <= '0;
            cnt_q           <= '0;
            ocnt_q          <= '0;
            frame_sum_q     <= '0;
            frame_ovf_cnt_q <= '0;
        end else begin
            state_q         <= state_d;
            acc_q           <= acc_d;
            cnt_q           <= cnt_d;
            ocnt_q          <= ocnt_d;
            frame_sum_q     <= frame_sum_d;
            frame_ovf_cnt_q <= frame_ovf_cnt_d;
        end
    end

    // Outputs are decoded from flops only.
    assign bus.in_ready      = (state_q == ST_ACC);
    assign bus.out_valid     = (state_q == ST_HOLD);
    assign bus.frame_sum     = frame_sum_q;
    assign bus.frame_ovf_cnt = frame_ovf_cnt_q;

endmodule

// File: tb/tb_frame_sum_accumulator.sv
`timescale 1ns/1ps
module tb_frame_sum_accumulator;
    localparam int FRAME_LEN = 4;
    localparam int ACC_W     = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    frame_sum_accumulator_if #(.ACC_W(ACC_W)) bus ();

    frame_sum_accumulator #(.FRAME_LEN(FRAME_LEN), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // True arithmetic value of the result currently presented.
    int cur_val = 0;

    // Behavioural model: true-value sums, overflow = value outside the
    // 6-bit signed range.
    int m_acc   = 0;
    int m_ocnt  = 0;
    int m_taken = 0;
    int m_sum   = 0;
    int m_fovf  = 0;
    bit m_hold  = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_acc = 0; m_ocnt = 0; m_taken = 0;
                m_sum = 0; m_fovf = 0; m_hold = 1'b0;
            end else if (clear) begin
                m_acc = 0; m_ocnt = 0; m_taken = 0; m_hold = 1'b0;
            end else if (m_hold) begin
                if (bus.out_ready) m_hold = 1'b0;
            end else if (bus.in_valid) begin
                m_acc   = m_acc + cur_val;
                m_ocnt  = m_ocnt + ((cur_val > 31 || cur_val < -32) ? 1 : 0);
                m_taken = m_taken + 1;
                if (m_taken == FRAME_LEN) begin
                    m_sum   = m_acc;
                    m_fovf  = m_ocnt;
                    m_acc   = 0;
                    m_ocnt  = 0;
                    m_taken = 0;
                    m_hold  = 1'b1;
                end
            end
        end
    end

    // Hand-computed literal expectations, handed to the compare process.
    int    lit_seq  = 0;
    string lit_name = "";
    int    lit_sum  = 0;
    int    lit_ocnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    initial begin
        int  fs;
        int  lit_done;
        bit  prev_ov;
        lit_done = 0;
        prev_ov  = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            fs = bus.frame_sum;
            chk("in_ready",      int'(bus.in_ready),  m_hold ? 0 : 1);
            chk("out_valid",     int'(bus.out_valid), m_hold ? 1 : 0);
            chk("frame_sum",     fs,                  m_sum);
            chk("frame_ovf_cnt", int'(bus.frame_ovf_cnt), m_fovf);
            if (bus.out_valid && !prev_ov)
                $display("frame t=%0t sum=%0d ovf_cnt=%0d", $time, fs, bus.frame_ovf_cnt);
            prev_ov = bus.out_valid;
            if (lit_done != lit_seq) begin
                chk({lit_name, "_sum"},  fs, lit_sum);
                chk({lit_name, "_ocnt"}, int'(bus.frame_ovf_cnt), lit_ocnt);
                $display("check %s sum=%0d ovf_cnt=%0d", lit_name, fs, bus.frame_ovf_cnt);
                lit_done = lit_seq;
            end
        end
    end

    task automatic drive(input int v, input bit vld, input bit ordy);
        bus.sum_in    = v[5:0];
        bus.ovf_in    = (v > 31 || v < -32);
        bus.in_valid  = vld;
        bus.out_ready = ordy;
        cur_val       = v;
        @(negedge clk);
    endtask

    task automatic lit(input string nm, input int s, input int o);
        lit_name = nm;
        lit_sum  = s;
        lit_ocnt = o;
        lit_seq  = lit_seq + 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int a, b, sa, sb, s6;
        bit ovf;
        bus.sum_in    = '0;
        bus.ovf_in    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame
        drive(5, 1, 1); drive(-3, 1, 1); drive(10, 1, 1); drive(-1, 1, 1);
        lit("basic", 11, 0);
        drive(0, 0, 1);
        drive(0, 0, 0);

        // Overflow reconstruction
        repeat (4) drive(34, 1, 0);
        lit("ovf_pos", 136, 4);
        drive(0, 0, 1);
        repeat (4) drive(-32, 1, 0);
        lit("ovf_neg", -128, 0);
        drive(0, 0, 1);

        // Backpressure
        repeat (4) drive(2, 1, 0);
        lit("bp_frame", 8, 0);
        repeat (5) drive(7, 1, 0);
        lit("bp_hold", 8, 0);
        drive(0, 0, 1);
        repeat (4) drive(1, 1, 1);
        lit("bp_next", 4, 0);
        drive(0, 0, 1);

        // Clear mid-frame
        drive(20, 1, 0); drive(20, 1, 0);
        clear = 1'b1;
        drive(9, 1, 0);
        clear = 1'b0;
        repeat (4) drive(-2, 1, 0);
        lit("clear", -8, 0);
        drive(0, 0, 1);

        // Reset in HOLD
        drive(5, 1, 0); drive(-3, 1, 0); drive(10, 1, 0); drive(-1, 1, 0);
        lit("rst_pre", 11, 0);
        drive(0, 0, 0);
        @(posedge clk);
        #2;
        lit("rst", 0, 0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        repeat (4) drive(3, 1, 0);
        lit("fresh", 12, 0);
        drive(0, 0, 1);

        // Random pairs through a reference 6-bit adder
        for (int i = 0; i < 1000; i++) begin
            a   = int'($urandom_range(0, 63));
            b   = int'($urandom_range(0, 63));
            sa  = (a > 31) ? a - 64 : a;
            sb  = (b > 31) ? b - 64 : b;
            s6  = (a + b) % 64;
            ovf = ((sa < 0) == (sb < 0)) && ((s6 >= 32) != (sa < 0));
            bus.sum_in    = s6[5:0];
            bus.ovf_in    = ovf;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 1) != 0);
            cur_val       = sa + sb;
            @(negedge clk);
        end

        drive(0, 0, 1);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/frame_sum_accumulator.md
# frame_sum_accumulator

Downstream consumer of the 6-bit signed ripple adder. Each cycle it can accept one adder result: the 6-bit sum plus the overflow flag. It rebuilds the exact 7-bit signed value of each result, accumulates FRAME_LEN results into a wide signed frame sum, and counts how many of those results overflowed. It then presents the completed frame on a valid/ready output handshake, and holds it until the consumer accepts it.

## Interface
- FRAME_LEN, default 4: results per frame; legal range 2..16.
- ACC_W, default 10: accumulator and frame_sum width. Must satisfy ACC_W >= 7 + clog2(FRAME_LEN).
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- clear  input  1  synchronous frame abort, active-high.
- sum_in  input  6  adder sum output, two's complement, possibly wrapped.
- ovf_in  input  1  adder signed-overflow flag for sum_in.
- in_valid  input  1  sum_in/ovf_in valid this cycle.
- in_ready  output  1  block accepts a result this cycle.
- frame_sum  output  ACC_W  signed sum of the last completed frame.
- frame_ovf_cnt  output  5  number of overflowed results in the last completed frame.
- out_valid  output  1  frame_sum/frame_ovf_cnt hold an unconsumed frame.
- out_ready  input  1  consumer accepts the frame.

## Operation
- **States**
  - ACC: collecting results.
  - HOLD: presenting a completed frame.
- **Decoded outputs:** in_ready = (state == ACC); out_valid = (state == HOLD). No combinational path from any input to any output.
- **Exact value reconstruction:** val7 = {sum_in[5] ^ ovf_in, sum_in}, a 7-bit signed value in the range -64..+62. It is sign-extended to ACC_W bits.
  - Example: sum_in = 6'b100010 with ovf_in = 1 gives +34.
- **Internal registers**
  - acc: ACC_W bits, signed.
  - cnt: 4 bits, results taken in the current frame.
  - ocnt: 5 bits, overflows in the current frame.
- **ACC state, on accept (in_valid & in_ready)**
  - If cnt < FRAME_LEN-1: acc += val7; ocnt += ovf_in; cnt += 1.
  - If cnt == FRAME_LEN-1 (last result of the frame):
    - frame_sum <= acc + val7; frame_ovf_cnt <= ocnt + ovf_in.
    - acc, cnt and ocnt <= 0.
    - State <= HOLD.
- **ACC state, no accept:** all registers hold.
- **HOLD state**
  - in_ready = 0; in_valid is ignored and no sample is lost or counted.
  - frame_sum and frame_ovf_cnt are stable.
  - On out_ready = 1: state <= ACC. frame_sum and frame_ovf_cnt keep their values until the next frame completes.
- **Arithmetic:** the ACC_W constraint guarantees no accumulator wrap for any legal input sequence. No saturation logic.
- **clear** (highest priority after reset) takes effect at the clock edge, from any state:
  - acc, cnt, ocnt <= 0; state <= ACC.
  - frame_sum and frame_ovf_cnt are unchanged.
  - A result presented in the same cycle as clear is dropped.
  - A HOLD frame is discarded: out_valid falls without a handshake.
- **Reset (rst_n low, any time, including mid-frame or in HOLD)**
  - state = ACC; acc, cnt, ocnt, frame_sum, frame_ovf_cnt = 0.
  - Output values: in_ready = 1, out_valid = 0.

## Timing
- Throughput in ACC: 1 result per cycle.
- Latency: out_valid rises on the clock edge that accepts the FRAME_LEN-th result, i.e. visible in the following cycle. frame_sum is valid in that same cycle.
- HOLD lasts at least 1 cycle. The frame is consumed on the edge where out_valid & out_ready are both 1; in_ready is 1 from the next cycle.
- Minimum frame period: FRAME_LEN + 1 cycles (one bubble per frame).
- Asynchronous reset assertion clears state immediately. Deassertion is taken synchronously to clk by the surrounding design.

## Test plan
- **Basic frame:** FRAME_LEN=4; sum_in = 5, -3, 10, -1 on consecutive cycles, ovf_in = 0 -> out_valid the next cycle, frame_sum = 11, frame_ovf_cnt = 0; with out_ready = 1, in_ready = 1 one cycle later.
- **Overflow reconstruction:** four results of sum_in = 6'b100010 with ovf_in = 1 -> frame_sum = 136, frame_ovf_cnt = 4. Also four of sum_in = 6'b100000 with ovf_in = 0 -> frame_sum = -128 (10'b1110000000), frame_ovf_cnt = 0.
- **Backpressure:** complete a frame, hold out_ready = 0 for 5 cycles while driving in_valid = 1 with sum_in = 7 -> out_valid stays 1, in_ready stays 0, outputs stable, nothing accumulated. Release out_ready, then feed 1, 1, 1, 1 -> next frame_sum = 4.
- **Clear mid-frame:** accept 20 and 20, assert clear for 1 cycle with in_valid = 1 and sum_in = 9, then feed -2, -2, -2, -2 -> frame_sum = -8; the value 9 is not counted; the prior frame_sum is unchanged until completion.
- **Reset in HOLD:** with out_valid = 1 and frame_sum = 11, pulse rst_n low mid-cycle -> out_valid = 0, frame_sum = 0, frame_ovf_cnt = 0, in_ready = 1 immediately. A fresh frame of 3, 3, 3, 3 then gives 12.
- **Random:** 1000 random (a, b) 6-bit pairs passed through a reference adder model, random in_valid and out_ready -> every frame_sum equals the sum of the true a + b values, and frame_ovf_cnt matches the model's overflow count.
